nl2_cln_rsp_route: RTL and testbench

- Return-path companion to the round-robin request selector.
- Records, in order, the requester index each time a selected request is accepted downstream.
- Routes the matching in-order response bursts back to that requester over per-port valid/ready handshakes.
- Sits between the shared downstream response channel and the LENGTH requester ports of a cluster-local interconnect.

---
 rtl/nl2_cln_rr_pkg.sv | 21 ++
 rtl/nl2_cln_idx_fifo.sv | 66 ++++++
 rtl/nl2_cln_rsp_route.sv | 96 +++++++++
 tb/tb_nl2_cln_rsp_route.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nl2_cln_rr_pkg.sv
// Shared definitions for the cluster-local round-robin request/response path.
//   CLN_RR_LENGTH / CLN_RR_ADDR : default requester count and index width
//   CLN_RSP_DEPTH               : default number of outstanding requests
//   CLN_RSP_DW                  : default response data width
//   rr_idx_t                    : requester index at the default width
//   rsp_beat_t                  : one response beat {data, last}
package nl2_cln_rr_pkg;

  localparam int CLN_RR_LENGTH = 2;
  localparam int CLN_RR_ADDR   = (CLN_RR_LENGTH > 1) ? $clog2(CLN_RR_LENGTH) : 1;
  localparam int CLN_RSP_DEPTH = 8;
  localparam int CLN_RSP_DW    = 64;

  typedef logic [CLN_RR_ADDR-1:0] rr_idx_t;

  typedef struct packed {
    logic [CLN_RSP_DW-1:0] data;
    logic                  last;
  } rsp_beat_t;

endpackage

// File: rtl/nl2_cln_idx_fifo.sv
// Generic synchronous FIFO with a combinational head (first-word-fall-through
// read of the registered storage) and registered full/empty/count.
//   clk, rst_a        : clock, asynchronous active-high reset of pointers/count
//   push, push_data   : write request; ignored while full
//   pop               : remove the head entry; ignored while empty
//   head              : entry at the read pointer (meaningless while empty)
//   full, empty, count: occupancy, all derived from registered state
module nl2_cln_idx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 1,
  localparam int PTRW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_a,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [PTRW:0] count
);

  logic [W-1:0]    mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PTRW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // A freshly written entry is only visible at the head from the next cycle:
  // the head reads storage, never the write port.
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/nl2_cln_rsp_route.sv
// Return-path router: remembers, in order, which requester each accepted
// downstream request came from and steers the in-order response bursts back
// to that requester.
//   clk, rst_a            : clock, asynchronous active-high reset
//   req_push, req_idx     : a request from requester req_idx was accepted
//   req_allow             : index FIFO has room; upstream gates acceptance
//   rsp_valid/ready/data/last : shared downstream response channel
//   out_valid[LENGTH]     : one-hot valid towards the head requester
//   out_ready[LENGTH]     : per-requester ready (only the head's is used)
//   out_data, out_last    : shared response data/last towards requesters
//   outstanding           : number of queued indices
//   err_unexp             : one-cycle pulse after a response arrived with
//                           nothing outstanding
module nl2_cln_rsp_route
  import nl2_cln_rr_pkg::*;
#(
  parameter int LENGTH = 2,
  parameter int ADDR   = $clog2(LENGTH),
  parameter int DEPTH  = CLN_RSP_DEPTH,
  parameter int PTRW   = $clog2(DEPTH),
  parameter int DW     = 64
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              req_push,
  input  logic [ADDR-1:0]   req_idx,
  output logic              req_allow,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [DW-1:0]     rsp_data,
  input  logic              rsp_last,
  output logic [LENGTH-1:0] out_valid,
  input  logic [LENGTH-1:0] out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  output logic [PTRW:0]     outstanding,
  output logic              err_unexp
);

  logic [ADDR-1:0]   head;
  logic              full;
  logic              empty;
  logic [LENGTH-1:0] head_sel;
  logic              head_ready;
  logic              fire;
  logic              pop;
  logic              err_reg;

  nl2_cln_idx_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR)
  ) u_idx_fifo (
    .clk       (clk),
    .rst_a     (rst_a),
    .push      (req_push),
    .push_data (req_idx),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (outstanding)
  );

  // Registered-only: no path from the response handshake back to upstream.
  assign req_allow = !full;

  // Decode the head index once; both valid steering and ready selection use it.
  for (genvar gi = 0; gi < LENGTH; gi++) begin : g_sel
    assign head_sel[gi]  = (head == ADDR'(gi));
    assign out_valid[gi] = rsp_valid && !empty && head_sel[gi];
  end

  assign head_ready = |(head_sel & out_ready);
  assign rsp_ready  = !empty && head_ready;
  assign out_data   = rsp_data;
  assign out_last   = rsp_last;

  // Only the last beat retires the index, so a burst stays on one port.
  assign fire = rsp_valid && rsp_ready;
  assign pop  = fire && rsp_last;

  // A beat with nothing outstanding is held off (rsp_ready=0), not dropped.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= rsp_valid && empty;
    end
  end

  assign err_unexp = err_reg;

  // Upstream must never offer a request while the index FIFO is full.
  push_when_full_a: assert property (@(posedge clk) disable iff (rst_a) !(req_push && full));

endmodule

// File: tb/tb_nl2_cln_rsp_route.sv
module tb_nl2_cln_rsp_route;

  localparam int LENGTH = 4;
  localparam int ADDR   = 2;
  localparam int DEPTH  = 8;
  localparam int PTRW   = 3;
  localparam int DW     = 64;

  logic              clk = 1'b0;
  logic              rst_a;
  logic              req_push;
  logic [ADDR-1:0]   req_idx;
  logic              req_allow;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic              rsp_last;
  logic [LENGTH-1:0] out_valid;
  logic [LENGTH-1:0] out_ready;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic [PTRW:0]     outstanding;
  logic              err_unexp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nl2_cln_rsp_route #(
    .LENGTH (LENGTH),
    .ADDR   (ADDR),
    .DEPTH  (DEPTH),
    .PTRW   (PTRW),
    .DW     (DW)
  ) dut (
    .clk         (clk),
    .rst_a       (rst_a),
    .req_push    (req_push),
    .req_idx     (req_idx),
    .req_allow   (req_allow),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .outstanding (outstanding),
    .err_unexp   (err_unexp)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // Outstanding requests are a plain queue of requester indices; the head of
  // the queue owns the response channel until a last beat is accepted.
  int          mq[$];
  logic        m_err;
  logic [3:0]  m_ov;
  logic        m_rdy;
  logic        m_fire;
  logic        m_empty;
  logic        m_full;

  initial begin
    m_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        mq.delete();
        m_err = 1'b0;
        chk("rst_allow", 64'(req_allow), 64'd1);
        chk("rst_ov",    64'(out_valid), 64'd0);
        chk("rst_rdy",   64'(rsp_ready), 64'd0);
        chk("rst_outst", 64'(outstanding), 64'd0);
        chk("rst_err",   64'(err_unexp), 64'd0);
      end else begin
        m_empty = (mq.size() == 0);
        m_full  = (mq.size() == DEPTH);
        m_ov    = 4'b0000;
        m_rdy   = 1'b0;
        if (!m_empty) begin
          if (rsp_valid) m_ov = 4'b0001 << mq[0];
          m_rdy = out_ready[mq[0]];
        end
        chk("out_valid",   64'(out_valid),   64'(m_ov));
        chk("rsp_ready",   64'(rsp_ready),   64'(m_rdy));
        chk("req_allow",   64'(req_allow),   64'(!m_full));
        chk("outstanding", 64'(outstanding), 64'(mq.size()));
        chk("err_unexp",   64'(err_unexp),   64'(m_err));
        chk("out_data",    out_data,         rsp_data);
        chk("out_last",    64'(out_last),    64'(rsp_last));
        // state for the coming clock edge
        m_err  = rsp_valid && m_empty;
        m_fire = rsp_valid && m_rdy;
        if (m_fire && rsp_last) begin
          $display("burst delivered to port %0d (outstanding %0d)", mq[0], mq.size() - 1);
          void'(mq.pop_front());
        end
        if (req_push && !m_full) begin
          mq.push_back(int'(req_idx));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic fired;

  initial begin
    rst_a = 1'b1; req_push = 1'b0; req_idx = '0; rsp_valid = 1'b0;
    rsp_data = '0; rsp_last = 1'b0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_allow", 64'(req_allow), 64'd1);
    chk("reset_outst", 64'(outstanding), 64'd0);
    rst_a = 1'b0;

    // single beat to port 2
    tick(); req_push = 1'b1; req_idx = 2'd2;
    tick(); req_push = 1'b0; rsp_valid = 1'b1; rsp_last = 1'b1;
    rsp_data = 64'h1234_5678_9abc_def0; out_ready = 4'b0100;
    #1;
    chk("t1_ov",    64'(out_valid), 64'h4);
    chk("t1_rdy",   64'(rsp_ready), 64'd1);
    chk("t1_outst1", 64'(outstanding), 64'd1);
    chk("t1_data",  out_data, 64'h1234_5678_9abc_def0);
    tick(); rsp_valid = 1'b0; out_ready = '0;
    #1 chk("t1_outst0", 64'(outstanding), 64'd0);
    $display("single-beat test done");

    // ordering 3,0,1
    tick(); req_push = 1'b1; req_idx = 2'd3;
    tick(); req_idx = 2'd0;
    tick(); req_idx = 2'd1;
    tick(); req_push = 1'b0; rsp_valid = 1'b1; rsp_last = 1'b1; out_ready = 4'hF;
    #1 chk("t2_ov0", 64'(out_valid), 64'h8);
    tick(); #1 chk("t2_ov1", 64'(out_valid), 64'h1);
    tick(); #1 chk("t2_ov2", 64'(out_valid), 64'h2);
    tick(); rsp_valid = 1'b0;
    #1 chk("t2_outst", 64'(outstanding), 64'd0);
    $display("ordering test done");

    // 4-beat burst with mid-burst backpressure on port 1
    tick(); req_push = 1'b1; req_idx = 2'd1;
    tick(); req_push = 1'b0; rsp_valid = 1'b1; rsp_last = 1'b0;
    out_ready = 4'b0010; rsp_data = 64'hA1;
    tick(); rsp_data = 64'hA2;
    tick(); out_ready = 4'b1000;
    #1 chk("t3_stall_rdy", 64'(rsp_ready), 64'd0);
    chk("t3_stall_ov", 64'(out_valid), 64'h2);
    tick();
    #1 chk("t3_stall_rdy2", 64'(rsp_ready), 64'd0);
    chk("t3_stall_ov2", 64'(out_valid), 64'h2);
    chk("t3_stall_outst", 64'(outstanding), 64'd1);
    tick(); out_ready = 4'b0010; rsp_data = 64'hA3;
    #1 chk("t3_resume_rdy", 64'(rsp_ready), 64'd1);
    tick(); rsp_last = 1'b1; rsp_data = 64'hA4;
    #1 chk("t3_prelast_outst", 64'(outstanding), 64'd1);
    tick(); rsp_valid = 1'b0; rsp_last = 1'b0; out_ready = '0;
    #1 chk("t3_outst0", 64'(outstanding), 64'd0);
    $display("burst/backpressure test done");

    // fill to DEPTH, free one, simultaneous push+pop, refill, drain across wrap
    for (int i = 0; i < DEPTH; i++) begin
      tick(); req_push = 1'b1; req_idx = ADDR'(i);
    end
    tick(); req_push = 1'b0;
    #1 chk("t4_full_allow", 64'(req_allow), 64'd0);
    chk("t4_full_outst", 64'(outstanding), 64'd8);
    rsp_valid = 1'b1; rsp_last = 1'b1; out_ready = 4'hF;
    #1 chk("t4_pop_rdy", 64'(rsp_ready), 64'd1);
    tick(); rsp_valid = 1'b0;
    #1 chk("t4_freed_outst", 64'(outstanding), 64'd7);
    chk("t4_freed_allow", 64'(req_allow), 64'd1);
    req_push = 1'b1; req_idx = 2'd3; rsp_valid = 1'b1;
    tick(); rsp_valid = 1'b0; req_idx = 2'd2;
    #1 chk("t4_pushpop_outst", 64'(outstanding), 64'd7);
    tick(); req_push = 1'b0;
    #1 chk("t4_refull_outst", 64'(outstanding), 64'd8);
    chk("t4_refull_allow", 64'(req_allow), 64'd0);
    rsp_valid = 1'b1;
    for (int i = 0; i < 20 && outstanding != 0; i++) tick();
    rsp_valid = 1'b0;
    #1 chk("t4_drained", 64'(outstanding), 64'd0);
    $display("full/wrap test done");

    // unexpected response
    tick(); rsp_valid = 1'b1; rsp_last = 1'b1;
    #1 chk("t5_unexp_rdy", 64'(rsp_ready), 64'd0);
    tick(); rsp_valid = 1'b0;
    #1 chk("t5_err_pulse", 64'(err_unexp), 64'd1);
    tick();
    #1 chk("t5_err_clear", 64'(err_unexp), 64'd0);
    $display("unexpected-response test done");

    // asynchronous reset in the middle of a burst
    tick(); req_push = 1'b1; req_idx = 2'd2;
    tick(); req_idx = 2'd1;
    tick(); req_idx = 2'd3;
    tick(); req_push = 1'b0; rsp_valid = 1'b1; rsp_last = 1'b0; out_ready = 4'b0100;
    tick();
    #2 rst_a = 1'b1;
    #1 chk("t6_rst_outst", 64'(outstanding), 64'd0);
    chk("t6_rst_ov", 64'(out_valid), 64'd0);
    chk("t6_rst_allow", 64'(req_allow), 64'd1);
    chk("t6_rst_rdy", 64'(rsp_ready), 64'd0);
    rsp_valid = 1'b0; out_ready = '0;
    tick(); tick(); rst_a = 1'b0;
    tick(); req_push = 1'b1; req_idx = 2'd0;
    tick(); req_push = 1'b0; rsp_valid = 1'b1; rsp_last = 1'b1; out_ready = 4'b0001;
    #1 chk("t6_post_ov", 64'(out_valid), 64'h1);
    chk("t6_post_rdy", 64'(rsp_ready), 64'd1);
    tick(); rsp_valid = 1'b0; rsp_last = 1'b0; out_ready = '0;
    #1 chk("t6_post_outst", 64'(outstanding), 64'd0);
    $display("reset test done");

    // randomized traffic; response beats stay stable until accepted
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      fired = rsp_valid && rsp_ready;
      @(posedge clk);
      #1;
      req_push = req_allow && ($urandom_range(0, 2) != 0);
      req_idx  = ADDR'($urandom_range(0, LENGTH - 1));
      if (!(rsp_valid && !fired)) begin
        rsp_valid = ($urandom_range(0, 3) != 0);
        rsp_data  = {$urandom, $urandom};
        rsp_last  = ($urandom_range(0, 2) == 0);
      end
      out_ready = LENGTH'($urandom_range(0, 15));
    end
    tick();
    req_push = 1'b0; rsp_valid = 1'b0; out_ready = '0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
